// File: rtl/uart_rx_assembler_if.sv
// UART RX FIFO / AES block handshake bundle for the word-to-block assembler.
`timescale 1ns/1ps

interface uart_rx_assembler_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_AES      = 128
);
    logic                  rx_empty;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rd_uart;
    logic                  clear;
    logic                  out_ready;
    logic [N_AES-1:0]      out;
    logic                  out_valid;

    // Producer side: FIFO status/data, abort and AES ready.
    modport master (
        output rx_empty, rx_data, clear, out_ready,
        input  rd_uart, out, out_valid
    );

    // Assembler side.
    modport slave (
        input  rx_empty, rx_data, clear, out_ready,
        output rd_uart, out, out_valid
    );
endinterface

// File: rtl/uart_rx_assembler.sv
// Pops 32-bit words from the UART RX FIFO and packs four of them into one
// 128-bit block for the AES input. Words 0..2 of the next block are collected
// while the previous block waits for the AES side; only the final word stalls.
`timescale 1ns/1ps

module uart_rx_assembler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_AES      = 128
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_rx_assembler_if.slave   bus
);

    localparam int unsigned BUF_W = 3 * DATA_WIDTH;

    // Collect state doubles as the count of words held in the buffer.
    typedef enum logic [1:0] {
        W0 = 2'd0,
        W1 = 2'd1,
        W2 = 2'd2,
        W3 = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q,   buf_d;
    logic [N_AES-1:0]   out_q,   out_d;
    logic               valid_q, valid_d;
    logic               rd_c;
    logic               consume_c;

    // Pop strobe: the final word waits until the presented block is gone or leaving.
    always_comb begin
        rd_c      = reset_n && !bus.rx_empty && !bus.clear &&
                    ((state_q != W3) || !valid_q || bus.out_ready);
        consume_c = valid_q && bus.out_ready;
    end

    // State, buffer and output block registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= W0;
            buf_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: word capture, block hand-off, consumption and abort.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        out_d   = out_q;
        valid_d = valid_q;

        if (bus.clear) begin
            state_d = W0;
            valid_d = 1'b0;
        end else begin
            if (consume_c) begin
                valid_d = 1'b0;
            end
            if (rd_c) begin
                case (state_q)
                    W0: begin
                        buf_d[DATA_WIDTH-1:0] = bus.rx_data;
                        state_d               = W1;
                    end
                    W1: begin
                        buf_d[2*DATA_WIDTH-1:DATA_WIDTH] = bus.rx_data;
                        state_d                          = W2;
                    end
                    W2: begin
                        buf_d[3*DATA_WIDTH-1:2*DATA_WIDTH] = bus.rx_data;
                        state_d                            = W3;
                    end
                    default: begin
                        out_d   = N_AES'({bus.rx_data, buf_q});
                        valid_d = 1'b1;
                        state_d = W0;
                    end
                endcase
            end
        end
    end

    assign bus.rd_uart   = rd_c;
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;

endmodule
